// File: rtl/snake_motion_ctrl.sv
// Snake game sequencer: owns segment coordinates and level, steps the snake on frame ticks.
// Optional body-collision detection is enabled by defining SELF_COLLIDE_EN.
module snake_motion_ctrl #(
  parameter int STEP_FRAMES = 8,
  parameter int START_X     = 100,
  parameter int START_Y     = 100,
  parameter int PARK        = 1023
) (
  input  logic         iVGA_CLK,
  input  logic         iRST_n,
  input  logic         iFrame_Tick,
  input  logic         iStart,
  input  logic         iDir_Valid,
  input  logic [1:0]   iDir,
  output logic [119:0] oSegX,
  output logic [119:0] oSegY,
  output logic [1:0]   oFlag,
  output logic         oGame_Over,
  output logic         oWin
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD, S_WIN} state_t;

  localparam logic [9:0] PARK_C   = 10'(PARK);
  localparam logic [9:0] START_YC = 10'(START_Y);
  localparam logic [7:0] CNT_LAST = 8'(STEP_FRAMES - 1);
  localparam logic [1:0] D_RIGHT  = 2'd0;
  localparam logic [1:0] D_DOWN   = 2'd1;
  localparam logic [1:0] D_LEFT   = 2'd2;
  localparam logic [1:0] D_UP     = 2'd3;

  state_t     state;
  logic [9:0] seg_x [12];
  logic [9:0] seg_y [12];
  logic [1:0] flag;
  logic [1:0] dir_pend;
  logic [1:0] dir_last;
  logic [7:0] cnt;
  logic       game_over;
  logic       win;

  logic       dir_ok, step, door, wall, body_hit, target;
  logic [1:0] dir_step;
  logic [9:0] head_x, head_y;
  logic [3:0] n_cur, n_next;

  function automatic logic [3:0] seg_count(input logic [1:0] lvl);
    case (lvl)
      2'd0:    return 4'd4;
      2'd1:    return 4'd8;
      default: return 4'd12;
    endcase
  endfunction

  function automatic logic [9:0] start_x(input int k);
    return 10'(START_X - 20 * k);
  endfunction

  always_comb begin
    n_cur    = seg_count(flag);
    n_next   = seg_count(flag + 2'd1);
    // A request exactly opposite the last executed step would fold the snake onto itself
    dir_ok   = iDir_Valid && ((iDir ^ dir_last) != 2'd2);
    dir_step = dir_ok ? iDir : dir_pend;
    step     = (state == S_RUN) && iFrame_Tick && (cnt == CNT_LAST);
    head_x   = seg_x[0];
    head_y   = seg_y[0];
    case (dir_step)
      D_RIGHT: head_x = seg_x[0] + 10'd20;
      D_DOWN:  head_y = seg_y[0] + 10'd20;
      D_LEFT:  head_x = seg_x[0] - 10'd20;
      default: head_y = seg_y[0] - 10'd20;
    endcase
    door     = (flag == 2'd2) && (head_x == 10'd0) && (head_y == 10'd100);
    wall     = (head_x < 10'd20) || (head_x >= 10'd600) ||
               (head_y < 10'd20) || (head_y >= 10'd440);
    body_hit = 1'b0;
`ifdef SELF_COLLIDE_EN
    // New seg k is old seg k-1, so compare the new head against the pre-step body
    for (int k = 1; k < 12; k++)
      if ((4'(k) < n_cur) && (head_x == seg_x[k-1]) && (head_y == seg_y[k-1]))
        body_hit = 1'b1;
`endif
    target   = ((flag == 2'd0) && (head_x == 10'd300) && (head_y == 10'd200)) ||
               ((flag == 2'd1) && (head_x == 10'd160) && (head_y == 10'd300));
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state     <= S_IDLE;
      flag      <= 2'd0;
      dir_pend  <= D_RIGHT;
      dir_last  <= D_RIGHT;
      cnt       <= 8'd0;
      game_over <= 1'b0;
      win       <= 1'b0;
      for (int k = 0; k < 12; k++) begin
        seg_x[k] <= PARK_C;
        seg_y[k] <= PARK_C;
      end
    end else if (iStart) begin
      state     <= S_RUN;
      flag      <= 2'd0;
      dir_pend  <= D_RIGHT;
      dir_last  <= D_RIGHT;
      cnt       <= 8'd0;
      game_over <= 1'b0;
      win       <= 1'b0;
      for (int k = 0; k < 12; k++) begin
        seg_x[k] <= (k < 4) ? start_x(k) : PARK_C;
        seg_y[k] <= (k < 4) ? START_YC   : PARK_C;
      end
    end else if (state == S_RUN) begin
      if (dir_ok) dir_pend <= iDir;
      if (iFrame_Tick) cnt <= step ? 8'd0 : cnt + 8'd1;
      if (step) begin
        dir_pend <= dir_step;
        dir_last <= dir_step;
        seg_x[0] <= head_x;
        seg_y[0] <= head_y;
        for (int k = 1; k < 12; k++)
          if (4'(k) < n_cur) begin
            seg_x[k] <= seg_x[k-1];
            seg_y[k] <= seg_y[k-1];
          end
        if (door) begin
          state <= S_WIN;
          win   <= 1'b1;
        end else if (wall || body_hit) begin
          state     <= S_DEAD;
          game_over <= 1'b1;
        end else if (target) begin
          flag     <= flag + 2'd1;
          dir_pend <= D_RIGHT;
          dir_last <= D_RIGHT;
          for (int k = 0; k < 12; k++) begin
            seg_x[k] <= (4'(k) < n_next) ? start_x(k) : PARK_C;
            seg_y[k] <= (4'(k) < n_next) ? START_YC   : PARK_C;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < 12; g++) begin : g_pack
    assign oSegX[10*g +: 10] = seg_x[g];
    assign oSegY[10*g +: 10] = seg_y[g];
  end

  assign oFlag      = flag;
  assign oGame_Over = game_over;
  assign oWin       = win;
endmodule

// File: tb/tb_snake_motion_ctrl.sv
// Scoreboard bench for snake_motion_ctrl: directed routes, expected states queued, monitor compares.
`timescale 1ns/1ps
module tb_snake_motion_ctrl;
  localparam int SF = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         frame_tick = 1'b0;
  logic         start = 1'b0;
  logic         dir_valid = 1'b0;
  logic [1:0]   dir = 2'd0;
  logic [119:0] seg_x, seg_y;
  logic [1:0]   flag;
  logic         game_over, win;

  snake_motion_ctrl dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iFrame_Tick(frame_tick), .iStart(start),
    .iDir_Valid(dir_valid), .iDir(dir), .oSegX(seg_x), .oSegY(seg_y),
    .oFlag(flag), .oGame_Over(game_over), .oWin(win)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int hx; int hy;
    int pk; int px; int py;
    int n;
    int fl; int ov; int wn;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [119:0] full_x(input int n);
    logic [119:0] v;
    for (int k = 0; k < 12; k++) v[10*k +: 10] = (k < n) ? 10'(100 - 20 * k) : 10'd1023;
    return v;
  endfunction

  function automatic logic [119:0] full_y(input int n);
    logic [119:0] v;
    for (int k = 0; k < 12; k++) v[10*k +: 10] = (k < n) ? 10'd100 : 10'd1023;
    return v;
  endfunction

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      int bad, ax, ay, full_ok;
      e = sb.pop_front();
      bad = 0; ax = 0; ay = 0; full_ok = 1;
      if (int'(seg_x[9:0]) != e.hx || int'(seg_y[9:0]) != e.hy) bad = 1;
      if (e.pk >= 0) begin
        ax = int'(seg_x[10*e.pk +: 10]);
        ay = int'(seg_y[10*e.pk +: 10]);
        if (ax != e.px || ay != e.py) bad = 1;
      end
      if (e.n >= 0) begin
        if (seg_x != full_x(e.n) || seg_y != full_y(e.n)) begin
          full_ok = 0;
          bad = 1;
        end
      end
      if (int'(flag) != e.fl || int'(game_over) != e.ov || int'(win) != e.wn) bad = 1;
      n_cmp++;
      if (bad != 0) begin
        n_bad++;
        $display("FAIL %s: got head=(%0d,%0d) seg%0d=(%0d,%0d) layout_ok=%0d flag=%0d over=%0d win=%0d; want head=(%0d,%0d) seg=(%0d,%0d) flag=%0d over=%0d win=%0d",
                 e.name, seg_x[9:0], seg_y[9:0], e.pk, ax, ay, full_ok, flag, game_over, win,
                 e.hx, e.hy, e.px, e.py, e.fl, e.ov, e.wn);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic dv, input logic [1:0] d);
    frame_tick = 1'b1; dir_valid = dv; dir = d;
    cyc();
    frame_tick = 1'b0; dir_valid = 1'b0;
    cyc();
  endtask

  task automatic idle_ticks(input int n);
    repeat (n) tick(1'b0, 2'd0);
  endtask

  task automatic steps(input int n);
    idle_ticks(n * SF);
  endtask

  task automatic turn(input logic [1:0] d);
    dir_valid = 1'b1; dir = d;
    cyc();
    dir_valid = 1'b0;
    cyc();
  endtask

  task automatic start_game();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
  endtask

  task automatic exp_push(input string name, input int hx, input int hy, input int pk,
                          input int px, input int py, input int n,
                          input int fl, input int ov, input int wn);
    exp_t e;
    e.name = name; e.hx = hx; e.hy = hy; e.pk = pk; e.px = px; e.py = py;
    e.n = n; e.fl = fl; e.ov = ov; e.wn = wn;
    sb.push_back(e);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation still running at %0t, want finish", $time);
    $fatal(1);
  end

  initial begin
    repeat (3) cyc();
    exp_push("reset", 1023, 1023, 11, 1023, 1023, 0, 0, 0, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    start_game();
    exp_push("start", 100, 100, 3, 40, 100, 4, 0, 0, 0);
    idle_ticks(SF - 1);
    exp_push("seven_ticks", 100, 100, -1, 0, 0, 4, 0, 0, 0);
    idle_ticks(1);
    exp_push("first_step", 120, 100, 3, 60, 100, -1, 0, 0, 0);
    turn(2'd2);
    steps(1);
    exp_push("reverse_ignored", 140, 100, 1, 120, 100, -1, 0, 0, 0);
    idle_ticks(SF - 1);
    tick(1'b1, 2'd1);
    exp_push("dir_with_tick", 140, 120, 1, 140, 100, -1, 0, 0, 0);

    start_game();
    exp_push("restart_in_run", 100, 100, 1, 80, 100, 4, 0, 0, 0);
    steps(24);
    exp_push("wall_minus1", 580, 100, 3, 520, 100, -1, 0, 0, 0);
    steps(1);
    exp_push("wall_hit", 600, 100, 1, 580, 100, -1, 0, 1, 0);
    steps(1);
    exp_push("dead_frozen", 600, 100, 3, 540, 100, -1, 0, 1, 0);

    start_game();
    exp_push("restart_dead", 100, 100, -1, 0, 0, 4, 0, 0, 0);
    steps(10);
    exp_push("l0_row", 300, 100, 3, 240, 100, -1, 0, 0, 0);
    turn(2'd1);
    steps(5);
    exp_push("l0_target", 100, 100, 7, 984, 100, 8, 1, 0, 0);
    steps(3);
    exp_push("l1_row", 160, 100, 7, 20, 100, -1, 1, 0, 0);
    turn(2'd1);
    steps(10);
    exp_push("l1_target", 100, 100, 11, 904, 100, 12, 2, 0, 0);

    turn(2'd1); steps(2);
    turn(2'd2); steps(4);
    turn(2'd3); steps(2);
    exp_push("l2_approach", 20, 100, 11, 40, 100, -1, 2, 0, 0);
    turn(2'd2);
    steps(1);
    exp_push("l2_door", 0, 100, 1, 20, 100, -1, 2, 0, 1);
    steps(1);
    exp_push("win_frozen", 0, 100, 1, 20, 100, -1, 2, 0, 1);

    start_game();
    exp_push("restart_win", 100, 100, -1, 0, 0, 4, 0, 0, 0);
    steps(10);
    turn(2'd1);
    steps(5);
    exp_push("l0_target_again", 100, 100, -1, 0, 0, 8, 1, 0, 0);
    turn(2'd1); steps(1);
    turn(2'd2); steps(1);
    turn(2'd3); steps(1);
`ifdef SELF_COLLIDE_EN
    exp_push("u_turn", 80, 100, 1, 80, 120, -1, 1, 1, 0);
`else
    exp_push("u_turn", 80, 100, 1, 80, 120, -1, 1, 0, 0);
`endif

    start_game();
    idle_ticks(3);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_push("async_reset", 1023, 1023, 5, 1023, 1023, 0, 0, 0, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    steps(1);
    exp_push("idle_ignores_tick", 1023, 1023, 0, 1023, 1023, 0, 0, 0, 0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) cyc();
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
